// File: rtl/sprite_plotter.sv
// Streams packed sprite RAM entries to the VGA adapter as single pixels offset by a latched origin.
// Define TRANSPARENT_EN to suppress plotting of entries whose colour equals TRANSP_COLOUR.
module sprite_plotter #(
  parameter int          READ_LAT      = 2,
  parameter int          MAX_WORDS     = 1024,
  parameter int          SCREEN_W      = 160,
  parameter int          SCREEN_H      = 120,
  parameter logic [2:0]  TRANSP_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  base_x,
  input  logic [6:0]  base_y,
  input  logic [15:0] ram_q,
  output logic [9:0]  ram_addr,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

`ifdef TRANSPARENT_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  localparam logic [9:0] LAST_ADDR = 10'(MAX_WORDS - 1);
  localparam logic [8:0] LIMIT_X   = 9'(SCREEN_W);
  localparam logic [7:0] LIMIT_Y   = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t               state_q, state_d;
  logic [7:0]           base_x_q, base_x_d;
  logic [6:0]           base_y_q, base_y_d;
  logic [9:0]           addr_q, addr_d;
  logic [READ_LAT-1:0]  tok_q, tok_d;
  logic                 term_q, term_d;
  logic                 ret_valid_q, ret_valid_d;
  logic [15:0]          ret_word_q, ret_word_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [2:0]           col_q, col_d;
  logic                 plot_q, plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tok_out, accept, term_now, last_issue, push;
  logic [5:0]           x_off, y_off;
  logic [2:0]           ent_col;
  logic [8:0]           sum_x;
  logic [7:0]           sum_y;
  logic                 clipped, transparent;

  // A token leaving the delay line marks ram_q as the word for its address;
  // once the terminator has been consumed, later speculative words are dropped.
  assign tok_out    = tok_q[READ_LAT-1];
  assign accept     = tok_out && !term_q;
  assign term_now   = accept && !ram_q[0];
  assign last_issue = (addr_q == LAST_ADDR);
  assign push       = (state_q == FETCH) && !term_now;

  assign x_off       = ret_word_q[15:10];
  assign y_off       = ret_word_q[9:4];
  assign ent_col     = ret_word_q[3:1];
  assign sum_x       = {1'b0, base_x_q} + {3'b000, x_off};
  assign sum_y       = {1'b0, base_y_q} + {2'b00, y_off};
  assign clipped     = (sum_x >= LIMIT_X) || (sum_y >= LIMIT_Y);
  assign transparent = TRANSP_EN && (ent_col == TRANSP_COLOUR);

  always_comb begin
    state_d     = state_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    addr_d      = addr_q;
    term_d      = term_q | term_now;
    ret_valid_d = accept;
    ret_word_d  = accept ? ram_q : ret_word_q;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    tok_d    = '0;
    tok_d[0] = push;
    for (int i = 1; i < READ_LAT; i++) begin
      tok_d[i] = tok_q[i-1];
    end
    if (term_now) begin
      tok_d = '0;
    end

    // Pixel coordinates only move when a pixel is actually written.
    if (ret_valid_q && !clipped && !transparent) begin
      plot_d = 1'b1;
      x_d    = sum_x[7:0];
      y_d    = sum_y[6:0];
      col_d  = ent_col;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          base_x_d = base_x;
          base_y_d = base_y;
          addr_d   = '0;
          busy_d   = 1'b1;
          term_d   = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (push && !last_issue) begin
          addr_d = addr_q + 10'd1;
        end
        if (term_now || last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((tok_q == '0) && !ret_valid_q) begin
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_x_q    <= '0;
      base_y_q    <= '0;
      addr_q      <= '0;
      tok_q       <= '0;
      term_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_word_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      addr_q      <= addr_d;
      tok_q       <= tok_d;
      term_q      <= term_d;
      ret_valid_q <= ret_valid_d;
      ret_word_q  <= ret_word_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr   = addr_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: two-cycle RAM model, per-cycle capture of each draw.
module tb_sprite_plotter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [15:0] ram_q;
  logic [9:0]  ram_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot, busy, done;

  always #5 clk = ~clk;

  sprite_plotter #(.READ_LAT(2), .MAX_WORDS(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
    .ram_q(ram_q), .ram_addr(ram_addr), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done)
  );

  // Sprite RAM: data appears two cycles after the address changes.
  logic [15:0] mem [0:1023];
  logic [9:0]  a1, a2;
  always @(posedge clk) begin
    a1 <= ram_addr;
    a2 <= a1;
  end
  assign ram_q = mem[a2];

  int checks = 0;
  int fails  = 0;

  logic       pv [0:31];
  logic [7:0] xv [0:31];
  logic [6:0] yv [0:31];
  logic [2:0] cv [0:31];
  logic       bv [0:31];
  int nplot, ndone, done_k, max_addr;

  function automatic logic [15:0] ent(input int xo, input int yo, input logic [2:0] c, input logic m);
    logic [5:0] xs, ys;
    xs = 6'(xo);
    ys = 6'(yo);
    return {xs, ys, c, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // k indexes the sample taken 1ns after edge N+k, where N is the edge accepting start.
  task automatic run_draw(input logic [7:0] bx, input logic [6:0] by, input int pulse_k, input int ncyc);
    base_x = bx;
    base_y = by;
    start  = 1'b1;
    @(posedge clk); #1;
    nplot = 0; ndone = 0; done_k = -1; max_addr = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      pv[k] = plot; xv[k] = vga_x; yv[k] = vga_y; cv[k] = vga_colour; bv[k] = busy;
      if (plot) nplot++;
      if (done) begin ndone++; done_k = k; end
      if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      if (k == pulse_k) begin
        start  = 1'b1;
        base_x = 8'd50;
        base_y = 7'd50;
      end
    end
    $display("draw base=(%0d,%0d) plots=%0d done_k=%0d max_addr=%0d", bx, by, nplot, done_k, max_addr);
  endtask

  task automatic load_basic();
    mem[0] = ent(0, 0, 3'b100, 1'b1);
    mem[1] = ent(1, 0, 3'b010, 1'b1);
    mem[2] = ent(2, 0, 3'b001, 1'b0);
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; start = 1'b0; base_x = '0; base_y = '0;
    for (int i = 0; i < 1024; i++) mem[i] = ent(0, 0, 3'b111, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", ram_addr, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic three-entry draw.
    load_basic();
    run_draw(8'd10, 7'd20, -1, 12);
    chk("basic_busy0", bv[0], 1);
    chk("basic_noplot3", pv[3], 0);
    chk("basic_p4", {pv[4], xv[4], yv[4], cv[4]}, {1'b1, 8'd10, 7'd20, 3'b100});
    chk("basic_p5", {pv[5], xv[5], yv[5], cv[5]}, {1'b1, 8'd11, 7'd20, 3'b010});
    chk("basic_p6", {pv[6], xv[6], yv[6], cv[6]}, {1'b1, 8'd12, 7'd20, 3'b001});
    chk("basic_noplot7", pv[7], 0);
    chk("basic_done_k", done_k, 7);
    chk("basic_ndone", ndone, 1);
    chk("basic_nplot", nplot, 3);
    chk("basic_busy7", bv[7], 1);
    chk("basic_busy8", bv[8], 0);

    // Start pulse with a new base while busy is ignored.
    run_draw(8'd10, 7'd20, 2, 12);
    chk("busy_p4", {pv[4], xv[4], yv[4]}, {1'b1, 8'd10, 7'd20});
    chk("busy_p6", {pv[6], xv[6], yv[6]}, {1'b1, 8'd12, 7'd20});
    chk("busy_nplot", nplot, 3);
    chk("busy_done_k", done_k, 7);
    run_draw(8'd50, 7'd50, -1, 12);
    chk("newbase_p4", {pv[4], xv[4], yv[4]}, {1'b1, 8'd50, 7'd50});
    chk("newbase_p6", {pv[6], xv[6], yv[6]}, {1'b1, 8'd52, 7'd50});

    // Start held during the done cycle is not accepted.
    run_draw(8'd10, 7'd20, 7, 16);
    chk("donecyc_done_k", done_k, 7);
    chk("donecyc_busy8", bv[8], 0);
    chk("donecyc_busy9", bv[9], 0);
    chk("donecyc_nplot", nplot, 3);

    // Clipping at the right and bottom edges.
    mem[0] = ent(0, 0, 3'b101, 1'b1);
    mem[1] = ent(1, 0, 3'b011, 1'b1);
    mem[2] = ent(2, 0, 3'b110, 1'b1);
    mem[3] = ent(0, 1, 3'b111, 1'b0);
    run_draw(8'd158, 7'd119, -1, 14);
    chk("clip_p4", {pv[4], xv[4], yv[4], cv[4]}, {1'b1, 8'd158, 7'd119, 3'b101});
    chk("clip_p5", {pv[5], xv[5], yv[5], cv[5]}, {1'b1, 8'd159, 7'd119, 3'b011});
    chk("clip_x_off", pv[6], 0);
    chk("clip_y_off", pv[7], 0);
    chk("clip_hold", {xv[7], yv[7], cv[7]}, {8'd159, 7'd119, 3'b011});
    chk("clip_nplot", nplot, 2);
    chk("clip_done_k", done_k, 8);
    chk("clip_ndone", ndone, 1);

    // No terminator: stops after MAX_WORDS entries.
    for (int i = 0; i < 16; i++) mem[i] = ent(i, 0, 3'b010, 1'b1);
    run_draw(8'd0, 7'd0, -1, 18);
    chk("noterm_nplot", nplot, 8);
    chk("noterm_max_addr", max_addr, 7);
    chk("noterm_ndone", ndone, 1);
    chk("noterm_done_k", done_k, 12);
    chk("noterm_last", {pv[11], xv[11]}, {1'b1, 8'd7});
    chk("noterm_after", pv[12], 0);

    // Transparent colour entries.
    mem[0] = ent(0, 0, 3'b000, 1'b1);
    mem[1] = ent(1, 0, 3'b111, 1'b1);
    mem[2] = ent(2, 0, 3'b000, 1'b0);
    run_draw(8'd5, 7'd5, -1, 12);
    chk("transp_p5", {pv[5], xv[5], yv[5], cv[5]}, {1'b1, 8'd6, 7'd5, 3'b111});
    chk("transp_done_k", done_k, 7);
`ifdef TRANSPARENT_EN
    chk("transp_p4", pv[4], 0);
    chk("transp_p6", pv[6], 0);
    chk("transp_nplot", nplot, 1);
`else
    chk("transp_p4", {pv[4], xv[4], cv[4]}, {1'b1, 8'd5, 3'b000});
    chk("transp_p6", {pv[6], xv[6], cv[6]}, {1'b1, 8'd7, 3'b000});
    chk("transp_nplot", nplot, 3);
`endif

    // Asynchronous reset in the middle of a draw.
    load_basic();
    base_x = 8'd10; base_y = 7'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_pre_plot", {plot, vga_x}, {1'b1, 8'd10});
    #2 resetn = 1'b0;
    #1;
    chk("midrst_plot", plot, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr", ram_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (plot || busy || done) cnt++;
    end
    chk("midrst_quiet", cnt, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Reads packed sprite entries out of the sprite RAM, which is loaded by the file-driven sprite loader, and streams them to the VGA adapter as single pixels.
- Each pixel is offset by a sprite screen position.
- Sits between the sprite RAM read port and the VGA adapter (x, y, colour, plot).
- One sprite is drawn per start request.

Parameters:
- READ_LAT, 2, cycles from ram_addr change to matching ram_q valid (legal 1..3).
- MAX_WORDS, 1024, hard limit on entries read per sprite.
- SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are clipped.
- TRANSP_COLOUR, 3'b000, colour treated as transparent when TRANSPARENT_EN is defined.

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- start  in  1  request to draw one sprite; sampled only in IDLE
- base_x  in  8  sprite origin x; latched on accepted start
- base_y  in  7  sprite origin y; latched on accepted start
- ram_q  in  16  sprite RAM read data {x_off[15:10], y_off[9:4], colour[3:1], more[0]}
- ram_addr  out  10  sprite RAM read address
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state IDLE; ram_addr, vga_x, vga_y, vga_colour, plot, busy, done all 0; pipeline valid bits cleared. Takes effect mid-draw with no further plots.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - start=1 at edge N: latch base_x/base_y, ram_addr<=0, busy<=1, state FETCH.
  - start=0: remain.
- FETCH:
  - Each cycle, push a valid token for the current ram_addr into a READ_LAT-deep shift register, then ram_addr<=ram_addr+1.
  - Leave for DRAIN when a returned word has more=0, or when ram_addr==MAX_WORDS-1 has been issued. No further addresses are issued.
- Data return: a token emerging from the shift register marks ram_q as the entry for that address. Process the entry only if no terminating entry has yet been processed for this draw. Later speculative words are discarded.
- Pixel output (registered, +1 cycle after data return):
  - vga_x <= base_x + x_off. The sum is computed 9 bits wide; the pixel is clipped if sum >= SCREEN_W.
  - vga_y <= base_y + y_off. The sum is computed 8 bits wide; the pixel is clipped if sum >= SCREEN_H.
  - vga_colour <= colour.
  - plot <= 1 unless clipped.
  - vga_x/vga_y/vga_colour hold their last values when plot=0.
- Latency: the entry at address 0 produces plot at edge N+1+READ_LAT+1. Subsequent entries follow back-to-back, one per cycle, with no bubbles.
- DRAIN: wait until the shift register is empty and the final pixel register has been issued, then go to FIN.
- FIN: done=1 for exactly one cycle; busy<=0; state IDLE. A start asserted in the same cycle as done is ignored; a start in the following cycle is accepted.
- Termination:
  - The entry with more=0 is itself drawn and is the last pixel.
  - If no such entry exists, the entry at MAX_WORDS-1 is last.
  - ram_addr never wraps within one draw.
- start while busy=1: ignored; base registers unchanged.
- base_x/base_y changes after acceptance: no effect on the current draw.

Optional Feature:
- Macro: TRANSPARENT_EN.
- Defined: entries with colour==TRANSP_COLOUR do not assert plot, but still consume their slot in the pixel stream. Termination and timing are unchanged.
- Undefined: every non-clipped entry plots, whatever its colour.

Test Plan:
- Basic draw: RAM holds 3 entries {0,0,3'b100,1}, {1,0,3'b010,1}, {2,0,3'b001,0}; base (10,20); start at edge N.
  - Required: plot high on edges N+4..N+6 (READ_LAT=2) with (10,20,100), (11,20,010), (12,20,001); done at N+7; busy low after.
- Clipping: base (158,119), entries offsets (0,0),(1,0),(2,0),(0,1), last has more=0.
  - Required: plot only for (158,119) and (159,119); two clipped slots have plot=0; done still pulses.
- No terminator: all entries more=1, MAX_WORDS=8.
  - Required: exactly 8 plot slots, ram_addr max 7, done once.
- Start while busy: pulse start with base (50,50) during a draw.
  - Required: ignored; all pixels keep the original base; a second start after done draws at the new base.
- Reset mid-draw: deassert resetn during FETCH.
  - Required: plot, busy, done and ram_addr 0 immediately (async); no plot after release until a new start.
- TRANSPARENT_EN defined, colours 000, 111, 000 (last more=0).
  - Required: plot only in the middle slot; done timing identical to the undefined build.
